// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg
//   Shared definitions for the byte-stream RAM loader: default RAM geometry
//   and the loader FSM state encoding.
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 3;   // 8-word RAM
    localparam int DATA_W_DEF = 16;  // two bytes per word

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        SETUP = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_loader.sv
// mem_loader
//   Assembles a little-endian byte stream into RAM words and writes a burst
//   of 'count' words starting at 'base_addr', wrapping around the RAM.
//   Each word takes LO -> HI -> SETUP -> WRITE, so address and data are held
//   stable for a full cycle before and during the write strobe.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        one-cycle burst request (ignored unless idle)
//   base_addr    first RAM address, sampled on accepted start
//   count        words to load (1..2**ADDR_W), sampled on accepted start
//   byte_valid   source presents a byte on byte_data
//   byte_data    byte stream, low byte of each word first
//   byte_ready   loader takes a byte this cycle (LO/HI only)
//   ram_address  RAM write address
//   ram_in       RAM write data
//   ram_load     RAM write strobe
//   busy         burst in progress
//   done         one-cycle burst-complete pulse
//   err          one-cycle illegal-count pulse
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Largest legal burst: one full pass over the RAM.
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   index;
    logic [7:0]        lo_q;

    // NOTE: every registered output is assigned for the state being entered,
    // not the state being left, so byte_ready/busy/done line up exactly with
    // the FSM state without any combinational decode on the outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            index       <= '0;
            lo_q        <= '0;
            byte_ready  <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            err      <= 1'b0;
            done     <= 1'b0;
            ram_load <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0 && count <= MAX_COUNT) begin
                            base_q     <= base_addr;
                            count_q    <= count;
                            index      <= '0;
                            state      <= LO;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                LO: begin
                    if (byte_valid && byte_ready) begin
                        lo_q  <= byte_data;
                        state <= HI;
                    end
                end

                HI: begin
                    // Address and data only ever change here, a full SETUP
                    // cycle ahead of the strobe.
                    if (byte_valid && byte_ready) begin
                        ram_in      <= DATA_W'({byte_data, lo_q});
                        ram_address <= base_q + index[ADDR_W-1:0];
                        byte_ready  <= 1'b0;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    ram_load <= 1'b1;
                    state    <= WRITE;
                end

                WRITE: begin
                    index <= index + 1'b1;
                    if (index + 1'b1 < count_q) begin
                        byte_ready <= 1'b1;
                        state      <= LO;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader
//   Self-checking bench for mem_loader. A behavioural RAM8 captures every
//   ram_load strobe; the expected RAM image is built from the burst rules
//   (word i of a burst lands at (base + i) mod 8) and compared after each
//   burst, together with strobe/done/err pulse counts and timing.
module tb_mem_loader;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic              busy;
    logic              done;
    logic              err;

    mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .count       (count),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .ram_address (ram_address),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural RAM8 and expected image
    logic [15:0] tb_ram  [0:7];
    logic [15:0] exp_mem [0:7];
    logic [15:0] words   [0:7];

    int load_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int done_cyc = 0;

    logic              prev_load = 1'b0;
    logic              prev_done = 1'b0;
    logic              prev_err  = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_data = '0;

    // Output monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (ram_load === 1'b1) begin
            load_cnt++;
            tb_ram[ram_address] = ram_in;
            check("load_one_cycle", prev_load, 0);
            check("addr_stable_before_load", ram_address, prev_addr);
            check("data_stable_before_load", ram_in, prev_data);
            check("load_while_busy", busy, 1);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_one_cycle", prev_done, 0);
            check("done_not_busy", busy, 0);
        end
        if (err === 1'b1) begin
            err_cnt++;
            check("err_one_cycle", prev_err, 0);
            check("err_not_busy", busy, 0);
        end
        if (byte_ready === 1'b1)
            check("ready_implies_busy", busy, 1);
        prev_load = ram_load;
        prev_done = done;
        prev_err  = err;
        prev_addr = ram_address;
        prev_data = ram_in;
    end

    task automatic compare_ram(input string tag);
        for (int a = 0; a < 8; a++)
            check($sformatf("%s_ram[%0d]", tag, a), tb_ram[a], exp_mem[a]);
    endtask

    // Runs one burst of 'cnt' words from words[]. mode: 0 = byte_valid held,
    // 1 = byte_valid every other cycle, 2 = random gaps. restart re-pulses
    // start mid-burst. abort_at >= 0 applies reset once that many bytes have
    // been accepted.
    task automatic run_burst(input string tag, input logic [2:0] base, input logic [3:0] cnt,
                             input int mode, input bit restart, input int abort_at);
        logic [7:0] bq[$];
        int pos, l0, d0, e0, t0, nexp;
        bit fin, v, rdy;
        bq = {};
        for (int i = 0; i < int'(cnt); i++) begin
            bq.push_back(words[i][7:0]);
            bq.push_back(words[i][15:8]);
        end
        nexp = (abort_at >= 0) ? abort_at / 2 : int'(cnt);
        for (int i = 0; i < nexp; i++)
            exp_mem[(int'(base) + i) % 8] = words[i];
        l0 = load_cnt; d0 = done_cnt; e0 = err_cnt;

        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        count      = cnt;
        byte_valid = (mode == 0);
        byte_data  = bq[0];
        t0  = cyc;
        pos = 0;
        fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            rdy = byte_ready;
            v   = byte_valid;
            @(posedge clk);
            if (v && rdy) pos++;
            @(negedge clk);
            if (done_cnt != d0) fin = 1'b1;
            if (abort_at >= 0 && pos == abort_at) fin = 1'b1;
            // Stale base/count after start must not matter.
            start     = restart && (k == 3);
            base_addr = ADDR_W'($urandom);
            count     = 4'($urandom_range(1, 8));
            case (mode)
                0:       byte_valid = (pos < bq.size());
                1:       byte_valid = (pos < bq.size()) && (k % 2 == 1);
                default: byte_valid = (pos < bq.size()) && ($urandom_range(0, 3) != 0);
            endcase
            byte_data = (pos < bq.size()) ? bq[pos] : 8'($urandom);
        end
        start      = 1'b0;
        byte_valid = 1'b0;

        if (abort_at >= 0) begin
            check({tag, "_reached_abort"}, pos, abort_at);
            reset = 1'b1;
            @(negedge clk);
            check({tag, "_reset_outputs"},
                  {ram_load, ram_address, ram_in, byte_ready, busy, done, err}, 0);
            reset = 1'b0;
            repeat (12) @(negedge clk);
            check({tag, "_loads"}, load_cnt - l0, nexp);
            check({tag, "_no_done"}, done_cnt - d0, 0);
            check({tag, "_busy_idle"}, busy, 0);
        end else begin
            check({tag, "_finished"}, fin, 1);
            check({tag, "_loads"}, load_cnt - l0, cnt);
            check({tag, "_done_pulses"}, done_cnt - d0, 1);
            check({tag, "_no_err"}, err_cnt - e0, 0);
            check({tag, "_bytes_used"}, pos, 2 * int'(cnt));
            check({tag, "_busy_after"}, busy, 0);
            if (mode == 0)
                check({tag, "_cycles"}, done_cyc - t0, 1 + 4 * int'(cnt));
        end
        compare_ram(tag);
    endtask

    task automatic run_err(input string tag, input logic [3:0] cnt);
        int l0, e0;
        l0 = load_cnt; e0 = err_cnt;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = ADDR_W'($urandom);
        count      = cnt;
        byte_valid = 1'b1;
        byte_data  = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_err_pulse"}, err_cnt - e0, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, byte_ready, 0);
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check({tag, "_err_total"}, err_cnt - e0, 1);
        check({tag, "_no_load"}, load_cnt - l0, 0);
        compare_ram(tag);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        count      = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        for (int a = 0; a < 8; a++) begin
            tb_ram[a]  = '0;
            exp_mem[a] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ram_load, ram_address, ram_in, byte_ready, busy, done, err}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed: base 2, three words, back-to-back bytes.
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC;
        run_burst("b2c3", 3'd2, 4'd3, 0, 1'b0, -1);

        // Directed: wrap from address 6.
        for (int i = 0; i < 4; i++) words[i] = 16'(i + 1);
        run_burst("wrap", 3'd6, 4'd4, 0, 1'b0, -1);

        // Illegal counts.
        run_err("cnt0", 4'd0);
        run_err("cnt9", 4'd9);
        run_err("cnt15", 4'd15);

        // Toggling byte_valid with a restart attempt mid-burst.
        words[0] = 16'hA55A; words[1] = 16'h0FF0;
        run_burst("toggle", 3'd0, 4'd2, 1, 1'b1, -1);

        // Full-RAM burst from address 7.
        for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
        run_burst("full", 3'd7, 4'd8, 0, 1'b0, -1);

        // Reset while in HI of word 2, then a clean burst.
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        run_burst("abort", 3'd0, 4'd4, 0, 1'b0, 3);
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        run_burst("post_abort", 3'd0, 4'd4, 2, 1'b0, -1);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) words[i] = 16'($urandom);
            run_burst($sformatf("rnd%0d", r), 3'($urandom), 4'($urandom_range(1, 8)),
                      int'($urandom_range(0, 2)), 1'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
